// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: access sizes, FSM states, default latency.
package data_mem_responder_pkg;

    localparam int MEM_LATENCY = 3;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_t;

    // Reserved encoding reports zero bytes, which the responder treats as an error.
    function automatic logic [2:0] access_bytes(access_size_t size);
        case (size)
            BYTE:    access_bytes = 3'd1;
            HALF:    access_bytes = 3'd2;
            WORD:    access_bytes = 3'd4;
            default: access_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the core memory stage and the responder.
interface data_mem_if
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    access_size_t          req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_mem_array.sv
// Byte-addressed storage: combinational little-endian read, byte-masked synchronous write.
module data_mem_array #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 200000,
    localparam int NB = DATA_WIDTH / 8,
    localparam int IW = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [NB-1:0]         wmask,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [7:0] mem [MEM_SIZE];

    logic [NB-1:0][IW-1:0] idx;
    logic [NB-1:0]         in_range;

    // Lanes past the end of the array read as zero and never write.
    always_comb begin
        rdata    = '0;
        idx      = '0;
        in_range = '0;
        for (int k = 0; k < NB; k++) begin
            in_range[k] = ({1'b0, addr} + (ADDR_WIDTH+1)'(k)) < (ADDR_WIDTH+1)'(MEM_SIZE);
            idx[k]      = IW'(addr + ADDR_WIDTH'(k));
            if (in_range[k])
                rdata[8*k +: 8] = mem[idx[k]];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++)
            if (we && wmask[k] && in_range[k])
                mem[idx[k]] <= wdata[8*k +: 8];
    end
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with programmable latency.
// Optional: define DATA_MEM_ALIGN_CHECK_EN to reject misaligned HALF/WORD accesses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 200000,
    parameter int LATENCY    = MEM_LATENCY
) (
    input  logic      clk,
    input  logic      reset,
    data_mem_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int EW = ADDR_WIDTH + 1;

    mem_resp_state_t       state;
    logic [3:0]            cnt;
    logic                  lat_write;
    access_size_t          lat_size;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;

    logic                  accept, go_resp;
    logic                  acc_write;
    access_size_t          acc_size;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [2:0]            nbytes;
    logic                  range_err, align_err, err;
    logic [NB-1:0]         mask;
    logic [DATA_WIDTH-1:0] mem_rdata, rdata_next;

    assign accept  = req_ready && bus.req_valid;
    assign go_resp = (state == IDLE && accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);

    // With LATENCY==1 the access happens on the accept edge, before the latch is loaded.
    assign acc_write = (state == IDLE) ? bus.req_write : lat_write;
    assign acc_size  = (state == IDLE) ? bus.req_size  : lat_size;
    assign acc_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;

    assign nbytes    = access_bytes(acc_size);
    // Extra bit keeps addresses near the top of the space from wrapping past the check.
    assign range_err = ({1'b0, acc_addr} + EW'(nbytes)) > EW'(MEM_SIZE);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign align_err = (acc_size == HALF && acc_addr[0]) ||
                       (acc_size == WORD && acc_addr[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif
    assign err = (nbytes == 3'd0) || range_err || align_err;

    always_comb begin
        mask       = '0;
        rdata_next = '0;
        for (int k = 0; k < NB; k++) begin
            mask[k] = k < int'(nbytes);
            if (mask[k])
                rdata_next[8*k +: 8] = mem_rdata[8*k +: 8];
        end
        if (acc_write || err)
            rdata_next = '0;
    end

    data_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (go_resp && acc_write && !err),
        .addr  (acc_addr),
        .wmask (mask),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    lat_write <= bus.req_write;
                    lat_size  <= bus.req_size;
                    lat_addr  <= bus.req_addr;
                    lat_wdata <= bus.req_wdata;
                    cnt       <= 4'(LATENCY - 1);
                    req_ready <= 1'b0;
                    state     <= (LATENCY > 1) ? WAIT : RESP;
                end
                WAIT: cnt <= cnt - 4'd1;
                RESP: if (bus.resp_ready) begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_rdata <= rdata_next;
                resp_error <= err;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_error = resp_error;
endmodule
